// File: rtl/grid_renderer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grid_renderer_pkg
//  Purpose  : Grid geometry and 6-bit {r,g,b} colour constants for the renderer.
//  Revision : 1.0 - initial release
// ============================================================================
package grid_renderer_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int OCC_AW = 11;

    localparam logic [5:0] COL_BLANK = 6'b000000;
    localparam logic [5:0] COL_WALL  = 6'b010101;
    localparam logic [5:0] COL_HEAD  = 6'b111100;
    localparam logic [5:0] COL_FOOD  = 6'b110000;
    localparam logic [5:0] COL_BODY  = 6'b001100;

endpackage
`default_nettype wire

// File: rtl/grid_renderer_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module   : sync_delay
//  Purpose  : N-stage shift register that idles high, used to keep the
//             active-low syncs aligned with the colour pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_delay #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/grid_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : grid_renderer
//  Purpose  : Two-stage pixel pipeline drawing walls, head, blinking food and
//             body cells of a 40x30 grid, with syncs aligned to colour.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_renderer
    import grid_renderer_pkg::*;
#(
    parameter int HRES      = 640,
    parameter int VRES      = 480,
    parameter int CELL_LOG2 = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              display_on,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic [5:0]        head_x,
    input  logic [4:0]        head_y,
    input  logic [5:0]        food_x,
    input  logic [4:0]        food_y,
    output logic [OCC_AW-1:0] occ_addr,
    input  logic              occ_data,
    output logic [5:0]        rgb,
    output logic              h_sync,
    output logic              v_sync,
    output logic              frame_tick
);

    // Stage 1 ----------------------------------------------------------------
    logic [9:0]        cell_x_d, cell_y_d, cell_x_q, cell_y_q;
    logic [OCC_AW-1:0] occ_addr_d, occ_addr_q;
    logic              disp_d, disp_q;
    logic              frame_tick_d, frame_tick_q;

    // Shadow coordinates and blink counter ------------------------------------
    logic [5:0] head_x_q, food_x_q;
    logic [4:0] head_y_q, food_y_q;
    logic [4:0] frame_cnt_q;

    // Stage 2 ----------------------------------------------------------------
    logic [5:0] rgb_d, rgb_q;
    logic       wall_hit, head_hit, food_hit, food_vis;
    logic [1:0] sync_dly;

    always_comb begin
        cell_x_d     = hpos >> CELL_LOG2;
        cell_y_d     = vpos >> CELL_LOG2;
        // y*40 + x as y*32 + y*8 + x
        occ_addr_d   = (OCC_AW'(cell_y_d) << 5) + (OCC_AW'(cell_y_d) << 3)
                     + OCC_AW'(cell_x_d);
        disp_d       = display_on && (hpos < 10'(HRES)) && (vpos < 10'(VRES));
        frame_tick_d = (hpos == 10'd0) && (vpos == 10'(VRES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_x_q     <= '0;
            cell_y_q     <= '0;
            occ_addr_q   <= '0;
            disp_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cell_x_q     <= cell_x_d;
            cell_y_q     <= cell_y_d;
            occ_addr_q   <= occ_addr_d;
            disp_q       <= disp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Coordinates only change between frames so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_x_q    <= '0;
            head_y_q    <= '0;
            food_x_q    <= '0;
            food_y_q    <= '0;
            frame_cnt_q <= '0;
        end else if (frame_tick_q) begin
            head_x_q    <= head_x;
            head_y_q    <= head_y;
            food_x_q    <= food_x;
            food_y_q    <= food_y;
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    always_comb begin
        wall_hit = (cell_x_q == 10'd0) || (cell_x_q == 10'(GRID_W - 1))
                || (cell_y_q == 10'd0) || (cell_y_q == 10'(GRID_H - 1));
        head_hit = (head_x_q < 6'(GRID_W)) && (head_y_q < 5'(GRID_H))
                && (cell_x_q == 10'(head_x_q)) && (cell_y_q == 10'(head_y_q));
        food_hit = (food_x_q < 6'(GRID_W)) && (food_y_q < 5'(GRID_H))
                && (cell_x_q == 10'(food_x_q)) && (cell_y_q == 10'(food_y_q));
        food_vis = ~frame_cnt_q[4];

        rgb_d = COL_BLANK;
        if (!disp_q)                  rgb_d = COL_BLANK;
        else if (wall_hit)            rgb_d = COL_WALL;
        else if (head_hit)            rgb_d = COL_HEAD;
        else if (food_hit && food_vis) rgb_d = COL_FOOD;
        else if (occ_data)            rgb_d = COL_BODY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= COL_BLANK;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    sync_delay #(
        .STAGES (2),
        .WIDTH  (2)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d_i   ({h_sync_in, v_sync_in}),
        .q_o   (sync_dly)
    );

    assign occ_addr   = occ_addr_q;
    assign rgb        = rgb_q;
    assign h_sync     = sync_dly[1];
    assign v_sync     = sync_dly[0];
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
